// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and data bundle between a conversion requester and the
// sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: one input bit per clock, result held
// in bcd_out between conversions for the downstream 7-segment decoders.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    bin_to_bcd_seq_if.slave    bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  accept_s;
    logic                  last_s;
    logic [BIN_W-1:0]      bin_r;
    logic [BCD_W-1:0]      scratch_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [BCD_W-1:0]      bcd_r;
    logic                  busy_r;
    logic                  done_r;
    logic [BCD_W-1:0]      scratch_adj_s;
    logic [BCD_W+BIN_W-1:0] cat_s;

    // Add 3 to every nibble >= 5, all digits evaluated on pre-shift values
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = s;
        for (int d = 0; d < DIGITS; d++) begin
            nib = s[4*d +: 4];
            if (nib >= 4'd5) begin
                r[4*d +: 4] = nib + 4'd3;
            end else begin
                r[4*d +: 4] = nib;
            end
        end
        return r;
    endfunction

    // Adjust-then-shift datapath for one iteration
    always_comb begin
        scratch_adj_s = add3_digits(scratch_r);
        cat_s         = {scratch_adj_s, bin_r} << 1;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s  = CONV;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                if (cnt_r == CNT_W'(BIN_W - 1)) begin
                    state_s = IDLE;
                    last_s  = 1'b1;
                end else begin
                    state_s = CONV;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Shift registers, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r     <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            bcd_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                bin_r     <= bus.bin_in;
                scratch_r <= '0;
                cnt_r     <= '0;
                busy_r    <= 1'b1;
            end else if (state_r == CONV) begin
                scratch_r <= cat_s[BCD_W+BIN_W-1:BIN_W];
                bin_r     <= cat_s[BIN_W-1:0];
                cnt_r     <= cnt_r + CNT_W'(1);
                // Final iteration publishes the post-shift digits
                if (last_s) begin
                    bcd_r  <= cat_s[BCD_W+BIN_W-1:BIN_W];
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.bcd_out = bcd_r;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed vector table, corner-case
// sequences (ignored start, async reset, hold) and a back-to-back full sweep.
module tb_bin_to_bcd_seq;
    localparam int BIN_W  = 12;
    localparam int DIGITS = 4;

    typedef struct {
        logic [11:0] bin;
        logic [15:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        assert (64'(10) ** DIGITS > (64'(1) << BIN_W) - 64'(1))
            else $fatal(1, "FAIL param_check DIGITS too small for BIN_W");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] dec_ref(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // One full conversion: request, wait for done, check latency/busy/result
    task automatic run_conv(input logic [11:0] v, input logic [15:0] exp, input string nm);
        int n;
        int bc;
        bit got;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = v;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bin_in = 12'($urandom);
        n = 0; bc = 0; got = 1'b0;
        while (!got && n < 40) begin
            if (bus.busy) bc++;
            @(negedge clk);
            n++;
            if (bus.done) got = 1'b1;
        end
        check({nm, "_done_seen"}, 32'(got), 32'd1);
        check({nm, "_latency"}, 32'(n), 32'd12);
        check({nm, "_busy_cycles"}, 32'(bc), 32'd12);
        check({nm, "_bcd"}, 32'(bus.bcd_out), 32'(exp));
        @(negedge clk);
        check({nm, "_done_single"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        vec_t vecs[13];
        int   n;
        int   dcnt;
        bit   bad_done;
        bit   bad_bcd;
        bit   bad_nib;
        logic [15:0] r;

        checks   = 0;
        failures = 0;
        bus.start  = 1'b0;
        bus.bin_in = 12'd0;

        vecs[0]  = '{12'd0,    16'h0000};
        vecs[1]  = '{12'd4095, 16'h4095};
        vecs[2]  = '{12'd255,  16'h0255};
        vecs[3]  = '{12'd1000, 16'h1000};
        vecs[4]  = '{12'd1,    16'h0001};
        vecs[5]  = '{12'd9,    16'h0009};
        vecs[6]  = '{12'd10,   16'h0010};
        vecs[7]  = '{12'd99,   16'h0099};
        vecs[8]  = '{12'd100,  16'h0100};
        vecs[9]  = '{12'd2048, 16'h2048};
        vecs[10] = '{12'd3999, 16'h3999};
        vecs[11] = '{12'd1234, 16'h1234};
        vecs[12] = '{12'd5,    16'h0005};

        rst = 1'b1;
        #12;
        check("reset_bcd", 32'(bus.bcd_out), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_conv(vecs[i].bin, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // start during conversion must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.bin_in = 12'd789;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1; dcnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (n == 4) begin bus.start = 1'b1; bus.bin_in = 12'd111; end
            else bus.start = 1'b0;
            @(negedge clk);
            n++;
            if (bus.done) begin
                dcnt++;
                check("ign_latency", 32'(n), 32'd13);
                check("ign_bcd", 32'(bus.bcd_out), 32'h0789);
            end
        end
        check("ign_done_count", 32'(dcnt), 32'd1);

        // asynchronous reset mid-conversion
        run_conv(12'd42, 16'h0042, "pre_rst");
        @(negedge clk);
        bus.start = 1'b1; bus.bin_in = 12'd999;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_bcd", 32'(bus.bcd_out), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_conv(12'd321, 16'h0321, "post_rst");

        // idle hold keeps result, no spurious done
        run_conv(12'd512, 16'h0512, "hold_pre");
        bad_done = 1'b0; bad_bcd = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.done) bad_done = 1'b1;
            if (bus.bcd_out !== 16'h0512) bad_bcd = 1'b1;
        end
        check("hold_done", 32'(bad_done), 32'd0);
        check("hold_bcd", 32'(bad_bcd), 32'd0);

        // full sweep, start held high so each done cycle accepts the next value
        @(negedge clk);
        bus.start = 1'b1; bus.bin_in = 12'd0;
        for (int v = 0; v < 4096; v++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.done && n < 40);
            check($sformatf("sweep_period_%0d", v), 32'(n), 32'd13);
            check($sformatf("sweep_bcd_%0d", v), 32'(bus.bcd_out), 32'(dec_ref(v)));
            r = bus.bcd_out;
            bad_nib = (r[3:0] > 4'd9) || (r[7:4] > 4'd9) || (r[11:8] > 4'd9) || (r[15:12] > 4'd9);
            check($sformatf("sweep_nibble_%0d", v), 32'(bad_nib), 32'd0);
            if (v == 4095) bus.start = 1'b0;
            else bus.bin_in = 12'(v + 1);
        end
        @(negedge clk);
        check("sweep_end_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
